cia_timer_bank: RTL and testbench

Parametrised interval-timer bank for the CIA-class peripheral set. It provides NUM_TIMERS independent down-counters of WIDTH bits, each with a reload latch, one-shot or continuous mode, a pulse or toggle output, and cascade chaining to the previous channel. A shared interrupt status/mask register drives a single active-low IRQ. The block sits on the same 8-bit chip-select/rw/register-select CPU bus as the other peripherals and is clocked by the fast peripheral clock with a phi2 enable.

---
 rtl/cia_timer_pkg.sv | 29 ++
 rtl/cia_timer_channel.sv | 111 +++++++++++
 rtl/cia_timer_bank.sv | 139 +++++++++++++
 tb/tb_cia_timer_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cia_timer_pkg.sv
// Shared constants for the CIA-class interval timer bank:
// control-register bit positions, count-source encodings and register map.
package cia_timer_pkg;

    // Control register bit positions
    localparam int CR_START      = 0;
    localparam int CR_OUT_EN     = 1;
    localparam int CR_TOGGLE     = 2;
    localparam int CR_ONESHOT    = 3;
    localparam int CR_FORCE_LOAD = 4;
    localparam int CR_SRC_LO     = 5;
    localparam int CR_SRC_HI     = 6;

    // Bits kept in the CR flop; FORCE_LOAD and bit 7 always read 0
    localparam logic [7:0] CR_KEEP = 8'h6F;

    typedef enum logic [1:0] {
        SRC_PHI2      = 2'b00,
        SRC_CNT       = 2'b01,
        SRC_CHAIN     = 2'b10,
        SRC_CHAIN_CNT = 2'b11
    } src_e;

    // Register map
    localparam logic [5:0] ICR_ADDR  = 6'h3E;
    localparam int         CH_STRIDE = 8;
    localparam logic [2:0] CR_OFS    = 3'd4;

endpackage

// File: rtl/cia_timer_channel.sv
// One timer channel: reload latch, down-counter, control register,
// one-shot handling and pulse/toggle output flop.
// Ports: clk/reset/phi2; lat_we (per latch byte), cr_we, wdata from the bus;
// cnt_rise/cnt_lvl from the count input; chain_in = underflow of the
// previous channel; count/cr_rd for readback; uf (combinational underflow);
// tmr_out.
module cia_timer_channel
    import cia_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               phi2,
    input  logic [WIDTH/8-1:0] lat_we,
    input  logic               cr_we,
    input  logic [7:0]         wdata,
    input  logic               cnt_rise,
    input  logic               cnt_lvl,
    input  logic               chain_in,
    output logic [WIDTH-1:0]   count,
    output logic [7:0]         cr_rd,
    output logic               uf,
    output logic               tmr_out
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] latch;
    logic [WIDTH-1:0] lat_nx;
    logic [WIDTH-1:0] cnt_nx;
    logic [7:0]       cr;
    logic             fl_pend;
    logic             load_now;
    logic             src_ok;
    logic             tick;
    logic             tgl;
    logic             pls;
    src_e             src;

    assign src = src_e'(cr[CR_SRC_HI:CR_SRC_LO]);

    always_comb begin
        src_ok = 1'b0;
        unique case (src)
            SRC_PHI2:      src_ok = 1'b1;
            SRC_CNT:       src_ok = cnt_rise;
            SRC_CHAIN:     src_ok = chain_in;
            SRC_CHAIN_CNT: src_ok = chain_in & cnt_lvl;
        endcase
    end

    // A pending force-load takes the phi2 and suppresses the tick
    assign load_now = phi2 & (fl_pend | (cr_we & wdata[CR_FORCE_LOAD]));
    assign tick     = phi2 & cr[CR_START] & src_ok & ~load_now;
    assign uf       = tick & (count == '0);

    // Latch value including this clk's byte writes, so a reload on the
    // same phi2 picks up freshly written bytes
    always_comb begin
        lat_nx = latch;
        for (int b = 0; b < NB; b++) begin
            if (lat_we[b]) lat_nx[8*b +: 8] = wdata;
        end
    end

    always_comb begin
        cnt_nx = count;
        if (load_now || (lat_we[NB-1] && !cr[CR_START])) begin
            cnt_nx = lat_nx;
        end else if (uf) begin
            cnt_nx = lat_nx;
        end else if (tick) begin
            cnt_nx = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch   <= '1;
            count   <= '1;
            cr      <= '0;
            fl_pend <= 1'b0;
            tgl     <= 1'b0;
            pls     <= 1'b0;
        end else begin
            latch <= lat_nx;
            count <= cnt_nx;
            if (cr_we) begin
                cr <= wdata & CR_KEEP;
            end else if (uf && cr[CR_ONESHOT]) begin
                cr[CR_START] <= 1'b0;
            end
            if (load_now) begin
                fl_pend <= 1'b0;
            end else if (cr_we && wdata[CR_FORCE_LOAD]) begin
                fl_pend <= 1'b1;
            end
            if (cr_we && wdata[CR_START] && !cr[CR_START]) begin
                tgl <= 1'b1;
            end else if (uf) begin
                tgl <= ~tgl;
            end
            if (phi2) pls <= uf;
        end
    end

    assign cr_rd   = cr;
    assign tmr_out = cr[CR_OUT_EN] & (cr[CR_TOGGLE] ? tgl : pls);

endmodule

// File: rtl/cia_timer_bank.sv
// Bank of NUM_TIMERS cascadable interval timers on the 8-bit peripheral bus.
// Ports: clk, reset (async, active high), phi2 enable; cs_n/rw/rs/db_in/db_out
// bus; cnt_in external count; tmr_out per channel; irq_n shared interrupt.
module cia_timer_bank
    import cia_timer_pkg::*;
#(
    parameter int NUM_TIMERS = 4,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  phi2,
    input  logic                  cs_n,
    input  logic                  rw,
    input  logic [5:0]            rs,
    input  logic [7:0]            db_in,
    output logic [7:0]            db_out,
    input  logic                  cnt_in,
    output logic [NUM_TIMERS-1:0] tmr_out,
    output logic                  irq_n
);

    localparam int NB = WIDTH / 8;

    logic                  bus_wr;
    logic                  bus_rd;
    logic                  icr_hit;
    logic [2:0]            ch_idx;
    logic [2:0]            ofs;
    logic                  cnt_q;
    logic                  cnt_rise;
    logic [NUM_TIMERS-1:0] uf;
    logic [NUM_TIMERS-1:0] mask;
    logic [NUM_TIMERS-1:0] status;
    logic [WIDTH-1:0]      count [NUM_TIMERS];
    logic [7:0]            cr_rd [NUM_TIMERS];
    logic                  clr_pend;
    logic                  clr_now;
    logic                  irq_q;
    logic [7:0]            rdata;

    assign bus_wr  = ~cs_n & ~rw;
    assign bus_rd  = ~cs_n & rw;
    assign icr_hit = (rs == ICR_ADDR);
    assign ch_idx  = 3'(rs / 6'(CH_STRIDE));
    assign ofs     = 3'(rs % 6'(CH_STRIDE));

    // cnt_in is only looked at on phi2
    assign cnt_rise = phi2 & cnt_in & ~cnt_q;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        logic          hit;
        logic [NB-1:0] lat_we;
        logic          chain_i;
        logic          uf_o;

        assign hit = bus_wr && (ch_idx == 3'(i));

        for (genvar b = 0; b < NB; b++) begin : g_b
            assign lat_we[b] = hit && (ofs == 3'(b));
        end

        // Channel 0 has no predecessor, so chained sources never tick
        if (i == 0) begin : g_first
            assign chain_i = 1'b0;
        end else begin : g_next
            assign chain_i = g_ch[i-1].uf_o;
        end

        cia_timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .phi2     (phi2),
            .lat_we   (lat_we),
            .cr_we    (hit && (ofs == CR_OFS)),
            .wdata    (db_in),
            .cnt_rise (cnt_rise),
            .cnt_lvl  (cnt_in),
            .chain_in (chain_i),
            .count    (count[i]),
            .cr_rd    (cr_rd[i]),
            .uf       (uf_o),
            .tmr_out  (tmr_out[i])
        );

        assign uf[i] = uf_o;
    end

    always_comb begin
        rdata = '0;
        if (icr_hit) begin
            rdata    = 8'(status);
            rdata[7] = irq_q;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (ch_idx == 3'(i)) begin
                    if (ofs == CR_OFS) begin
                        rdata = cr_rd[i];
                    end else begin
                        for (int b = 0; b < NB; b++) begin
                            if (ofs == 3'(b)) rdata = count[i][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // An ICR read arms a clear that fires on the next phi2; an underflow
    // on that same phi2 survives the clear
    assign clr_now = phi2 & clr_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_out   <= '0;
            cnt_q    <= 1'b0;
            mask     <= '0;
            status   <= '0;
            clr_pend <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (bus_rd) db_out <= rdata;
            if (phi2) cnt_q <= cnt_in;
            if (bus_wr && icr_hit) begin
                if (db_in[7]) mask <= mask | db_in[NUM_TIMERS-1:0];
                else          mask <= mask & ~db_in[NUM_TIMERS-1:0];
            end
            status <= clr_now ? uf : (status | uf);
            if (bus_rd && icr_hit) clr_pend <= 1'b1;
            else if (phi2)         clr_pend <= 1'b0;
            irq_q <= clr_now ? 1'b0 : (irq_q | (|(status & mask)));
        end
    end

    assign irq_n = ~irq_q;

endmodule

// File: tb/tb_cia_timer_bank.sv
// Directed self-checking bench for cia_timer_bank (4 channels, 16 bits).
// Expected values are hand-computed per step.
module tb_cia_timer_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       phi2 = 1'b0;
    logic       cs_n = 1'b1;
    logic       rw = 1'b1;
    logic [5:0] rs = '0;
    logic [7:0] db_in = '0;
    logic [7:0] db_out;
    logic       cnt_in = 1'b0;
    logic [3:0] tmr_out;
    logic       irq_n;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cia_timer_bank #(
        .NUM_TIMERS(4),
        .WIDTH(16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .phi2    (phi2),
        .cs_n    (cs_n),
        .rw      (rw),
        .rs      (rs),
        .db_in   (db_in),
        .db_out  (db_out),
        .cnt_in  (cnt_in),
        .tmr_out (tmr_out),
        .irq_n   (irq_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; rw = 1'b0; rs = a; db_in = d;
        @(negedge clk);
        cs_n = 1'b1; rw = 1'b1;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; rw = 1'b1; rs = a;
        @(negedge clk);
        cs_n = 1'b1;
        d = db_out;
    endtask

    // n consecutive phi2 clocks; records tmr_out[ch] after each one
    task automatic run(input int n, input int ch, output int np,
                       output int first, output int second,
                       output logic [31:0] pat);
        np = 0; first = 0; second = 0; pat = '0;
        phi2 = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            pat[k-1] = tmr_out[ch];
            if (tmr_out[ch]) begin
                np++;
                if (np == 1) first = k;
                else if (np == 2) second = k;
            end
        end
        phi2 = 1'b0;
    endtask

    logic [7:0]  d;
    logic [31:0] pat;
    int          np, f1, f2;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_db_out", db_out, 8'h00);
        chk("rst_tmr_out", tmr_out, 4'h0);
        chk("rst_irq_n", irq_n, 1'b1);
        reset = 1'b0;
        rd(6'h00, d); chk("rst_cnt0_lo", d, 8'hFF);
        rd(6'h04, d); chk("rst_cr0", d, 8'h00);
        rd(6'h3E, d); chk("rst_icr", d, 8'h00);

        // Channel 0 continuous, latch 3
        wr(6'h00, 8'h03);
        wr(6'h01, 8'h00);
        wr(6'h04, 8'h13);
        wr(6'h04, 8'h03);
        run(12, 0, np, f1, f2, pat);
        chk("c0_uf_count", np, 2);
        chk("c0_first_uf", f1, 5);
        chk("c0_second_uf", f2, 9);
        chk("c0_irq_masked", irq_n, 1'b1);
        rd(6'h00, d); chk("c0_cnt_lo", d, 8'h00);
        rd(6'h3E, d); chk("c0_icr", d, 8'h01);

        // Clear status, unmask ch0, underflow on the clearing phi2
        wr(6'h04, 8'h02);
        run(1, 0, np, f1, f2, pat);
        rd(6'h3E, d); chk("icr_cleared", d, 8'h00);
        wr(6'h3E, 8'h81);
        chk("mask_no_irq", irq_n, 1'b1);
        wr(6'h04, 8'h03);
        run(1, 0, np, f1, f2, pat);
        chk("coinc_pulse", pat[0], 1'b1);
        chk("irq_not_yet", irq_n, 1'b1);
        @(negedge clk);
        chk("irq_low", irq_n, 1'b0);
        rd(6'h3E, d); chk("icr_read_81", d, 8'h81);
        run(1, 0, np, f1, f2, pat);
        chk("irq_cleared", irq_n, 1'b1);
        @(negedge clk);
        chk("irq_stays_clr", irq_n, 1'b1);
        wr(6'h04, 8'h00);

        // Channel 2 one-shot, latch 5
        wr(6'h10, 8'h05);
        wr(6'h11, 8'h00);
        wr(6'h14, 8'h1B);
        run(12, 2, np, f1, f2, pat);
        chk("os_uf_count", np, 1);
        chk("os_first_uf", f1, 7);
        rd(6'h14, d); chk("os_cr", d, 8'h0A);
        rd(6'h10, d); chk("os_cnt_lo", d, 8'h05);
        rd(6'h11, d); chk("os_cnt_hi", d, 8'h00);
        chk("os_irq_masked", irq_n, 1'b1);

        // Cascade: ch0 latch 1, ch1 latch 2 chained, ch1 toggle out
        wr(6'h00, 8'h01);
        wr(6'h01, 8'h00);
        wr(6'h08, 8'h02);
        wr(6'h09, 8'h00);
        wr(6'h0C, 8'h47);
        chk("casc_tgl_init", tmr_out[1], 1'b1);
        wr(6'h04, 8'h01);
        run(12, 1, np, f1, f2, pat);
        chk("casc_tgl_pat", pat[11:0], 12'h81F);
        rd(6'h3E, d); chk("casc_icr", d, 8'h87);

        // Latch 0 toggles every phi2
        wr(6'h18, 8'h00);
        wr(6'h19, 8'h00);
        wr(6'h1C, 8'h07);
        run(4, 3, np, f1, f2, pat);
        chk("l0_tgl_pat", pat[3:0], 4'hA);

        // Asynchronous reset mid-count
        phi2 = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_db_out", db_out, 8'h00);
        chk("mid_rst_tmr", tmr_out, 4'h0);
        chk("mid_rst_irq", irq_n, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_irq", irq_n, 1'b1);
            chk("post_rst_tmr", tmr_out, 4'h0);
        end
        phi2 = 1'b0;
        rd(6'h00, d); chk("post_cnt_lo", d, 8'hFF);
        rd(6'h01, d); chk("post_cnt_hi", d, 8'hFF);
        rd(6'h0C, d); chk("post_cr1", d, 8'h00);
        rd(6'h3E, d); chk("post_icr", d, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
